// File: rtl/reaction_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reaction_round_ctrl
// Description : Round sequencer for the reaction mini-game. Conditions the
//               raw KEY bus, runs arm / random hold-off / GO / capture /
//               result, measures reaction time in ms and drives the red LEDs
//               and six seven-segment digits.
//               Optional macro REACTION_DEBOUNCE_EN adds a 10 ms stability
//               filter on every synchronised button.
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_round_ctrl #(
  parameter int          CLK_HZ       = 50000000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter logic [10:0] DELAY_MASK   = 11'h7FF,
  parameter int          MAX_MS       = 9999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  buttons,
  output logic [9:0]  red_leds,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [13:0] elapsed_ms,
  output logic [1:0]  winner,
  output logic        foul,
  output logic        result_valid
);

  localparam int              TICKS_PER_MS = CLK_HZ / 1000;
  localparam int              TW           = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TW-1:0]   c_TICK_LAST  = TW'(TICKS_PER_MS - 1);
  localparam logic [13:0]     c_MAX        = 14'(MAX_MS);
  localparam logic [15:0]     c_MIN_DELAY  = 16'(MIN_DELAY_MS);
  localparam logic [6:0]      c_BLANK      = 7'h7F;
  localparam logic [6:0]      c_SEG_F      = 7'h0E;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_GO     = 3'd2,
    S_RESULT = 3'd3,
    S_FOUL   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    w_btn_clean;
  logic [3:0]    r_prev;
  logic [3:0]    r_press;
  logic [15:0]   r_lfsr;
  logic [TW-1:0] r_tick_cnt;
  logic          w_ms_tick;
  logic [15:0]   r_delay;
  logic [15:0]   r_bcd;
  logic [13:0]   r_bin;
  logic [13:0]   r_elapsed;
  logic [1:0]    r_winner;
  logic          r_foul;
  logic          r_result_valid;

  logic          w_start;
  logic          w_player_any;
  logic [1:0]    w_player_id;
  logic          w_enter_armed;
  logic          w_enter_go;
  logic          w_end_result;
  logic          w_end_foul;
  logic          w_cnt_en;
  logic [1:0]    w_win_nxt;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = c_BLANK;
    endcase
  endfunction

  // Four-digit BCD increment with ripple carry between digits
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] w_res;
    logic        w_carry;
    w_res   = v;
    w_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          w_res[4*i +: 4] = 4'd0;
        end else begin
          w_res[4*i +: 4] = v[4*i +: 4] + 4'd1;
          w_carry         = 1'b0;
        end
      end
    end
    return w_res;
  endfunction

  // Invert the active-low KEYs and bring them into the clock domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 4'd0;
      r_sync2 <= 4'd0;
    end else begin
      r_sync1 <= ~buttons;
      r_sync2 <= r_sync1;
    end
  end

`ifdef REACTION_DEBOUNCE_EN
  localparam int DB_CYCLES = 10 * TICKS_PER_MS;
  localparam int DW        = $clog2(DB_CYCLES + 1);

  for (genvar gi = 0; gi < 4; gi++) begin : g_db
    logic [DW-1:0] r_cnt;
    logic          r_raw;
    logic          r_stable;

    // A level is accepted only after it has held unchanged for 10 ms
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt    <= '0;
        r_raw    <= 1'b0;
        r_stable <= 1'b0;
      end else if (r_sync2[gi] != r_raw) begin
        r_raw <= r_sync2[gi];
        r_cnt <= '0;
      end else if (r_cnt == DW'(DB_CYCLES - 1)) begin
        r_stable <= r_raw;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_btn_clean[gi] = r_stable;
  end
`else
  assign w_btn_clean = r_sync2;
`endif

  // Registered rising-edge detect: one-cycle press strobe per button
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev  <= 4'd0;
      r_press <= 4'd0;
    end else begin
      r_prev  <= w_btn_clean;
      r_press <= w_btn_clean & ~r_prev;
    end
  end

  assign w_start      = r_press[0];
  assign w_player_any = |r_press[3:1];
  assign w_player_id  = r_press[1] ? 2'd1 :
                        r_press[2] ? 2'd2 :
                        r_press[3] ? 2'd3 : 2'd0;

  // Free-running Galois LFSR; nonzero seed keeps it off the all-zero lockup
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_lfsr <= 16'hACE1;
    else          r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign w_ms_tick = (r_tick_cnt == c_TICK_LAST);

  // Millisecond prescaler, realigned whenever a timed phase begins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      r_tick_cnt <= '0;
    else if (w_enter_armed || w_enter_go) r_tick_cnt <= '0;
    else if (w_ms_tick)                r_tick_cnt <= '0;
    else                               r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // Random hold-off: loaded on arming, counted down once per ms while armed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_delay <= 16'd0;
    else if (w_enter_armed)
      r_delay <= c_MIN_DELAY + {5'd0, (r_lfsr[10:0] & DELAY_MASK)};
    else if (r_state == S_ARMED && w_ms_tick && r_delay != 16'd0)
      r_delay <= r_delay - 16'd1;
  end

  // Reaction timer kept in BCD for display and binary for the result port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcd <= 16'd0;
      r_bin <= 14'd0;
    end else if (w_enter_go) begin
      r_bcd <= 16'd0;
      r_bin <= 14'd0;
    end else if (w_cnt_en) begin
      r_bcd <= bcd_inc(r_bcd);
      r_bin <= r_bin + 14'd1;
    end
  end

  // Round outcome registers and the single-cycle result strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_winner       <= 2'd0;
      r_foul         <= 1'b0;
      r_elapsed      <= 14'd0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= w_end_result | w_end_foul;
      if (w_enter_armed) begin
        r_winner <= 2'd0;
        r_foul   <= 1'b0;
      end else if (w_end_result) begin
        r_winner  <= w_win_nxt;
        r_foul    <= 1'b0;
        r_elapsed <= r_bin;
      end else if (w_end_foul) begin
        r_winner  <= w_win_nxt;
        r_foul    <= 1'b1;
        r_elapsed <= 14'd0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state, phase strobes and display decode
  always_comb begin
    w_state_nxt   = r_state;
    w_enter_armed = 1'b0;
    w_enter_go    = 1'b0;
    w_end_result  = 1'b0;
    w_end_foul    = 1'b0;
    w_cnt_en      = 1'b0;
    w_win_nxt     = w_player_id;
    red_leds      = 10'h000;
    hex0          = c_BLANK;
    hex1          = c_BLANK;
    hex2          = c_BLANK;
    hex3          = c_BLANK;
    hex4          = c_BLANK;
    hex5          = c_BLANK;

    case (r_state)
      S_IDLE: begin
        hex0 = seg7(r_bcd[3:0]);
        hex1 = seg7(r_bcd[7:4]);
        hex2 = seg7(r_bcd[11:8]);
        hex3 = seg7(r_bcd[15:12]);
        if (w_start) begin
          w_state_nxt   = S_ARMED;
          w_enter_armed = 1'b1;
        end
      end
      S_ARMED: begin
        red_leds = 10'h200;
        // An early press wins over a simultaneous delay expiry
        if (w_player_any) begin
          w_state_nxt = S_FOUL;
          w_end_foul  = 1'b1;
        end else if (w_ms_tick && r_delay <= 16'd1) begin
          w_state_nxt = S_GO;
          w_enter_go  = 1'b1;
        end
      end
      S_GO: begin
        red_leds = 10'h0FF;
        hex0     = seg7(r_bcd[3:0]);
        hex1     = seg7(r_bcd[7:4]);
        hex2     = seg7(r_bcd[11:8]);
        hex3     = seg7(r_bcd[15:12]);
        if (w_player_any) begin
          w_state_nxt  = S_RESULT;
          w_end_result = 1'b1;
        end else if (r_bin >= c_MAX) begin
          w_state_nxt  = S_RESULT;
          w_end_result = 1'b1;
          w_win_nxt    = 2'd0;
        end else if (w_ms_tick) begin
          w_cnt_en = 1'b1;
        end
      end
      S_RESULT: begin
        red_leds = (r_winner == 2'd0) ? 10'h000 : (10'h001 << r_winner);
        hex0     = seg7(r_bcd[3:0]);
        hex1     = seg7(r_bcd[7:4]);
        hex2     = seg7(r_bcd[11:8]);
        hex3     = seg7(r_bcd[15:12]);
        hex5     = (r_winner == 2'd0) ? c_BLANK : seg7({2'b00, r_winner});
        if (w_start) begin
          w_state_nxt   = S_ARMED;
          w_enter_armed = 1'b1;
        end
      end
      S_FOUL: begin
        red_leds = 10'h3FF;
        hex0     = c_SEG_F;
        hex1     = c_SEG_F;
        hex2     = c_SEG_F;
        hex3     = c_SEG_F;
        hex5     = seg7({2'b00, r_winner});
        if (w_start) begin
          w_state_nxt   = S_ARMED;
          w_enter_armed = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign elapsed_ms   = r_elapsed;
  assign winner       = r_winner;
  assign foul         = r_foul;
  assign result_valid = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_reaction_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reaction_round_ctrl
// Description : Self-checking bench for reaction_round_ctrl at 4 cycles/ms,
//               5 ms fixed hold-off, 20 ms timeout. Directed and random rounds
//               are predicted from round timing arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_round_ctrl;

  localparam int TPM   = 4;
  localparam int MIN_D = 5;
  localparam int MAXMS = 20;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  buttons = 4'hF;
  logic [9:0]  red_leds;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [13:0] elapsed_ms;
  logic [1:0]  winner;
  logic        foul;
  logic        result_valid;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  reaction_round_ctrl #(
    .CLK_HZ      (4000),
    .MIN_DELAY_MS(MIN_D),
    .DELAY_MASK  (11'h000),
    .MAX_MS      (MAXMS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .buttons     (buttons),
    .red_leds    (red_leds),
    .hex0        (hex0),
    .hex1        (hex1),
    .hex2        (hex2),
    .hex3        (hex3),
    .hex4        (hex4),
    .hex5        (hex5),
    .elapsed_ms  (elapsed_ms),
    .winner      (winner),
    .foul        (foul),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_digits(input string tag, input int val);
    check({tag, ".hex0"}, {9'd0, hex0}, {9'd0, SEG[val % 10]});
    check({tag, ".hex1"}, {9'd0, hex1}, {9'd0, SEG[(val / 10) % 10]});
    check({tag, ".hex2"}, {9'd0, hex2}, {9'd0, SEG[(val / 100) % 10]});
    check({tag, ".hex3"}, {9'd0, hex3}, {9'd0, SEG[(val / 1000) % 10]});
  endtask

  // One round: start press, optional player press whose pin change is first
  // sampled 'offs' edges after the start pin. Timing model: a press acts 3
  // edges after its pin is sampled; GO comes MIN_D ms after arming; the
  // shown time is whole ms elapsed since GO.
  task automatic play_round(input logic [2:0] pmask, input int offs, input string tag);
    int  s, a, g, e, q, ms, w, stop, pulses, run;
    bit  is_foul;
    s       = cyc + 1;
    a       = s + 3;
    g       = a + TPM * MIN_D;
    q       = (pmask != 3'b000) ? s + offs : 0;
    w       = pmask[0] ? 1 : pmask[1] ? 2 : pmask[2] ? 3 : 0;
    is_foul = 1'b0;
    if (pmask != 3'b000 && q + 3 <= g) begin
      is_foul = 1'b1;
      e       = q + 3;
      ms      = 0;
    end else if (pmask != 3'b000 && q + 3 <= g + TPM * MAXMS + 1) begin
      e  = q + 3;
      ms = (q + 2 - g) / TPM;
      if (ms > MAXMS) ms = MAXMS;
    end else begin
      e  = g + TPM * MAXMS + 1;
      ms = MAXMS;
      w  = 0;
    end
    stop   = (e + 2 > q + 2) ? e + 2 : q + 2;
    pulses = 0;
    buttons[0] = 1'b0;
    while (cyc < stop) begin
      if (cyc + 1 == s + 2) buttons[0] = 1'b1;
      if (pmask != 3'b000 && cyc + 1 == q) buttons[3:1] = ~pmask;
      step();
      if (result_valid === 1'b1) pulses++;
      if (cyc == e) begin
        check({tag, ".valid"},   {15'd0, result_valid}, 16'd1);
        check({tag, ".winner"},  {14'd0, winner}, 16'(w));
        check({tag, ".foul"},    {15'd0, foul}, {15'd0, is_foul});
        check({tag, ".elapsed"}, {2'd0, elapsed_ms}, is_foul ? 16'd0 : 16'(ms));
        check({tag, ".hex4"},    {9'd0, hex4}, 16'h007F);
        if (is_foul) begin
          check({tag, ".leds"}, {6'd0, red_leds}, 16'h03FF);
          check({tag, ".hex0F"}, {9'd0, hex0}, 16'h000E);
          check({tag, ".hex3F"}, {9'd0, hex3}, 16'h000E);
          check({tag, ".hex5"}, {9'd0, hex5}, {9'd0, SEG[w]});
        end else begin
          check({tag, ".leds"}, {6'd0, red_leds}, (w == 0) ? 16'h0000 : (16'h0001 << w));
          check_digits(tag, ms);
          check({tag, ".hex5"}, {9'd0, hex5}, (w == 0) ? 16'h007F : {9'd0, SEG[w]});
        end
      end else if (cyc == e + 1) begin
        check({tag, ".valid_drop"}, {15'd0, result_valid}, 16'd0);
        check({tag, ".winner_hold"}, {14'd0, winner}, 16'(w));
      end else if (cyc >= g && cyc < e) begin
        run = (cyc - g) / TPM;
        if (run > MAXMS) run = MAXMS;
        check({tag, ".go_leds"}, {6'd0, red_leds}, 16'h00FF);
        check({tag, ".go_hex0"}, {9'd0, hex0}, {9'd0, SEG[run % 10]});
        check({tag, ".go_hex1"}, {9'd0, hex1}, {9'd0, SEG[(run / 10) % 10]});
      end else if (cyc >= a && cyc < e) begin
        check({tag, ".armed_leds"}, {6'd0, red_leds}, 16'h0200);
        check({tag, ".armed_hex3"}, {9'd0, hex3}, 16'h007F);
      end
    end
    buttons = 4'hF;
    check({tag, ".pulses"}, 16'(pulses), 16'd1);
    repeat (4) step();
  endtask

  initial begin
    int s;
    logic [2:0] pm;
    int of;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst.leds",  {6'd0, red_leds}, 16'h0000);
    check("rst.valid", {15'd0, result_valid}, 16'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle.valid", {15'd0, result_valid}, 16'd0);
      check("idle.leds",  {6'd0, red_leds}, 16'h0000);
    end
    check_digits("idle", 0);
    check("idle.hex4",    {9'd0, hex4}, 16'h007F);
    check("idle.hex5",    {9'd0, hex5}, 16'h007F);
    check("idle.winner",  {14'd0, winner}, 16'd0);
    check("idle.foul",    {15'd0, foul}, 16'd0);
    check("idle.elapsed", {2'd0, elapsed_ms}, 16'd0);

    // Directed rounds
    play_round(3'b010, 49,  "p2_7ms");
    play_round(3'b100, 8,   "p3_foul");
    play_round(3'b000, 0,   "timeout");
    play_round(3'b101, 40,  "p1p3_tie");
    play_round(3'b001, 20,  "press_at_go_edge");
    play_round(3'b010, 21,  "first_go_cycle");
    play_round(3'b100, 101, "press_at_max");
    play_round(3'b001, 102, "press_after_max");

    // Random rounds
    for (int i = 0; i < 10; i++) begin
      pm = 3'($urandom_range(0, 7));
      of = int'($urandom_range(1, 110));
      play_round(pm, of, $sformatf("rand%0d", i));
    end

    // Asynchronous reset in the middle of GO
    s = cyc + 1;
    buttons[0] = 1'b0;
    step();
    step();
    buttons[0] = 1'b1;
    while (cyc < s + 3 + TPM * MIN_D + 30) step();
    check("midgo.leds", {6'd0, red_leds}, 16'h00FF);
    reset_n = 1'b0;
    #1;
    check("arst.leds",    {6'd0, red_leds}, 16'h0000);
    check_digits("arst", 0);
    check("arst.hex4",    {9'd0, hex4}, 16'h007F);
    check("arst.hex5",    {9'd0, hex5}, 16'h007F);
    check("arst.winner",  {14'd0, winner}, 16'd0);
    check("arst.foul",    {15'd0, foul}, 16'd0);
    check("arst.elapsed", {2'd0, elapsed_ms}, 16'd0);
    check("arst.valid",   {15'd0, result_valid}, 16'd0);
    step();
    step();
    reset_n = 1'b1;
    repeat (3) step();
    check("post_rst.leds", {6'd0, red_leds}, 16'h0000);
    play_round(3'b010, 49, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
